// File: rtl/rst_seq_defs.sv
// Shared definitions for the reset synchroniser/sequencer: FSM states,
// width helpers and the parameter legality check.
package rst_seq_defs;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      HOLD      = 2'd1,
      RELEASE   = 2'd2,
      DONE      = 2'd3
   } seq_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = 1; v < value; v = v * 2) r++;
      return r;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic bit params_legal(input int num_stages, input int num_ch,
                                       input int min_assert, input int gap_cycles);
      return (num_stages >= 2) && (num_ch >= 1) && (min_assert >= 1) && (gap_cycles >= 1);
   endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Async-assert / sync-deassert shift chain; rdy rises on edge NUM_STAGES
// after RST falls.
module rst_sync_chain #(
   parameter int NUM_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   output logic rdy,
   output logic rdy_next
);

   logic [NUM_STAGES-1:0] sync_q;
   logic [NUM_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[NUM_STAGES-2:0], 1'b1};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sync_q <= '0;
      else     sync_q <= sync_d;
   end

   // rdy_next is the value the last stage takes on the coming edge
   assign rdy      = sync_q[NUM_STAGES-1];
   assign rdy_next = sync_d[NUM_STAGES-1];

endmodule

// File: rtl/rst_sync_seq.sv
// Reset sequencer: holds NUM_CH active-low resets, then releases them one by
// one GAP_CYCLES apart; a software request re-runs the whole sequence.
//
// state     | meaning
// WAIT_SYNC | waiting for the synchronised deassertion of RST
// HOLD      | all channels asserted for MIN_ASSERT edges
// RELEASE   | releasing channel idx after GAP_CYCLES edges
// DONE      | all channels released, outputs held
module rst_sync_seq
   import rst_seq_defs::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int NUM_CH     = 4,
   parameter int MIN_ASSERT = 4,
   parameter int GAP_CYCLES = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SW_RST_REQ,
   output logic              SW_RST_ACK,
   output logic [NUM_CH-1:0] SYNC_RST,
   output logic              RST_DONE
);

   localparam int CNT_W = clog2(max2(MIN_ASSERT, GAP_CYCLES)) + 1;
   localparam int IDX_W = clog2(NUM_CH + 1);
   localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(MIN_ASSERT - 1);
   localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   if (!params_legal(NUM_STAGES, NUM_CH, MIN_ASSERT, GAP_CYCLES)) begin : g_illegal_params
      $error("rst_sync_seq: illegal parameter set");
   end

   logic rdy;
   logic rdy_next;

   rst_sync_chain #(.NUM_STAGES(NUM_STAGES)) u_sync_chain (
      .CLK      (CLK),
      .RST      (RST),
      .rdy      (rdy),
      .rdy_next (rdy_next)
   );

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [NUM_CH-1:0] sync_rst_q, sync_rst_d;
   logic              rst_done_q, rst_done_d;
   logic              sw_ack_q, sw_ack_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      sync_rst_d = sync_rst_q;
      rst_done_d = rst_done_q;
      sw_ack_d   = 1'b0;

      unique case (state_q)
         // leave on the same edge that rdy rises
         WAIT_SYNC: begin
            if (rdy_next) begin
               state_d = HOLD;
               cnt_d   = '0;
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_TC) begin
               sync_rst_d[0] = 1'b1;
               cnt_d         = '0;
               if (NUM_CH == 1) begin
                  rst_done_d = 1'b1;
                  state_d    = DONE;
               end else begin
                  idx_d   = IDX_W'(1);
                  state_d = RELEASE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RELEASE: begin
            if (cnt_q == GAP_TC) begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (idx_q == IDX_W'(i)) sync_rst_d[i] = 1'b1;
               end
               cnt_d = '0;
               if (idx_q == LAST_IDX) begin
                  rst_done_d = 1'b1;
                  state_d    = DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
         end
         default: state_d = WAIT_SYNC;
      endcase

      // software restart overrides any progress once the chain is ready
      if (SW_RST_REQ && rdy && (state_q != WAIT_SYNC)) begin
         sync_rst_d = '0;
         rst_done_d = 1'b0;
         sw_ack_d   = 1'b1;
         state_d    = HOLD;
         cnt_d      = '0;
         idx_d      = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= WAIT_SYNC;
         cnt_q      <= '0;
         idx_q      <= '0;
         sync_rst_q <= '0;
         rst_done_q <= 1'b0;
         sw_ack_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sync_rst_q <= sync_rst_d;
         rst_done_q <= rst_done_d;
         sw_ack_q   <= sw_ack_d;
      end
   end

   assign SYNC_RST   = sync_rst_q;
   assign RST_DONE   = rst_done_q;
   assign SW_RST_ACK = sw_ack_q;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Scoreboard bench: two sequencer instances (default and corner parameters)
// against an edge-count reference model of the release schedule.
module tb_rst_sync_seq;

   typedef struct packed {
      logic [3:0] sync;
      logic       done;
      logic       ack;
   } exp_t;

   logic       CLK        = 1'b0;
   logic       RST        = 1'b1;
   logic       SW_RST_REQ = 1'b0;

   logic       ack_a, done_a;
   logic [3:0] sync_a;
   logic       ack_b, done_b;
   logic [0:0] sync_b;

   rst_sync_seq u_dut_a (
      .CLK        (CLK),
      .RST        (RST),
      .SW_RST_REQ (SW_RST_REQ),
      .SW_RST_ACK (ack_a),
      .SYNC_RST   (sync_a),
      .RST_DONE   (done_a)
   );

   rst_sync_seq #(
      .NUM_STAGES (3),
      .NUM_CH     (1),
      .MIN_ASSERT (1),
      .GAP_CYCLES (1)
   ) u_dut_b (
      .CLK        (CLK),
      .RST        (RST),
      .SW_RST_REQ (SW_RST_REQ),
      .SW_RST_ACK (ack_b),
      .SYNC_RST   (sync_b),
      .RST_DONE   (done_b)
   );

   always #5 CLK = ~CLK;

   int   tests = 0;
   int   fails = 0;
   exp_t qa[$];
   exp_t qb[$];

   // model parameters per instance: [0] = defaults, [1] = corner
   int ns[2]   = '{2, 3};
   int nch[2]  = '{4, 1};
   int mina[2] = '{4, 1};
   int gap[2]  = '{8, 1};

   // n = edges since RST fell, start = edge of the current sequence start
   int n[2];
   int start[2];
   bit ackm[2];

   function automatic void model_reset(input int d);
      n[d]     = 0;
      start[d] = -1;
      ackm[d]  = 1'b0;
   endfunction

   function automatic void model_edge(input int d, input logic rst, input logic req);
      if (rst) begin
         model_reset(d);
         return;
      end
      n[d]++;
      if (start[d] < 0) begin
         ackm[d] = 1'b0;
         if (n[d] >= ns[d]) start[d] = n[d];
      end else begin
         ackm[d] = req;
         if (req) start[d] = n[d];
      end
   endfunction

   function automatic exp_t model_out(input int d);
      exp_t e;
      e = '0;
      for (int i = 0; i < nch[d]; i++) begin
         if (start[d] >= 0 && n[d] >= start[d] + mina[d] + i * gap[d]) e.sync[i] = 1'b1;
      end
      e.done = (start[d] >= 0) && (n[d] >= start[d] + mina[d] + (nch[d] - 1) * gap[d]);
      e.ack  = ackm[d];
      return e;
   endfunction

   task automatic check(input string name, input exp_t act, input exp_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: sync/done/ack actual=%b/%b/%b required=%b/%b/%b at %0t",
                  name, act.sync, act.done, act.ack, exp.sync, exp.done, exp.ack, $time);
      end
   endtask

   // one clock cycle: model the edge, queue the response, then drive inputs
   task automatic step(input bit rst_next, input bit req_next, input bit pulse);
      @(posedge CLK);
      for (int d = 0; d < 2; d++) begin
         model_edge(d, RST, SW_RST_REQ);
         if (rst_next || pulse) model_reset(d);
      end
      qa.push_back(model_out(0));
      qb.push_back(model_out(1));
      #2;
      RST        = rst_next | pulse;
      SW_RST_REQ = req_next;
      if (pulse) begin
         #1;
         RST = 1'b0;
      end
   endtask

   initial begin : monitor
      exp_t e;
      exp_t act;
      forever begin
         @(negedge CLK);
         if (qa.size() != 0) begin
            e   = qa.pop_front();
            act = {sync_a, done_a, ack_a};
            check("dut_a", act, e);
         end
         if (qb.size() != 0) begin
            e   = qb.pop_front();
            act = {3'b000, sync_b, done_b, ack_b};
            check("dut_b", act, e);
         end
      end
   end

   initial begin : stimulus
      int r;
      model_reset(0);
      model_reset(1);

      // power-on
      repeat (3) step(1'b1, 1'b0, 1'b0);
      repeat (40) step(1'b0, 1'b0, 1'b0);

      // async pulse between edges while in DONE
      step(1'b0, 1'b0, 1'b1);
      repeat (40) step(1'b0, 1'b0, 1'b0);

      // single software request in DONE
      step(1'b0, 1'b1, 1'b0);
      repeat (35) step(1'b0, 1'b0, 1'b0);

      // mid-sequence restart
      step(1'b0, 1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      repeat (35) step(1'b0, 1'b0, 1'b0);

      // request held for several edges
      repeat (5) step(1'b0, 1'b1, 1'b0);
      repeat (35) step(1'b0, 1'b0, 1'b0);

      // RST and request together, then request at edge 1 in WAIT_SYNC
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      repeat (40) step(1'b0, 1'b0, 1'b0);

      // randomized traffic
      repeat (600) begin
         r = int'($urandom_range(0, 199));
         step(r < 2, $urandom_range(0, 19) == 0, (r == 2) || (r == 3));
      end
      repeat (40) step(1'b0, 1'b0, 1'b0);

      @(negedge CLK);
      #1;
      tests++;
      if (qa.size() != 0 || qb.size() != 0) begin
         fails++;
         $display("FAIL drain: queued entries actual=%0d/%0d required=0/0", qa.size(), qb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rst_sync_seq.md
Name: rst_sync_seq

Overview:
- Parametrised reset synchroniser and sequencer for one clock domain.
- Asserts NUM_CH active-low domain resets asynchronously and holds them for a minimum time.
- Releases the resets one channel at a time, in fixed order, spaced GAP_CYCLES apart.
- Accepts a synchronous software reset request that re-runs the full sequence without toggling the hard reset. Sits at the top level, between the reset pad or POR and the per-block reset inputs (register file, ALU, UART, FIFO).

Parameters:
NUM_STAGES, 2, synchroniser depth for the reset-deassertion edge; legal range >= 2
NUM_CH, 4, number of sequenced reset outputs; legal range >= 1
MIN_ASSERT, 4, cycles all outputs stay asserted after the synchronised release or a software request; legal range >= 1
GAP_CYCLES, 8, cycles between consecutive channel releases; legal range >= 1

Ports:
CLK  in  1  single clock
RST  in  1  asynchronous, active-high reset; assertion is asynchronous, deassertion is synchronised internally
SW_RST_REQ  in  1  synchronous software reset request, level-sampled each edge
SW_RST_ACK  out  1  one-cycle pulse; request accepted
SYNC_RST  out  NUM_CH  active-low per-channel resets (0 = in reset)
RST_DONE  out  1  high once all channels are released

Behaviour:
- Edge numbering: edge 1 is the first CLK rising edge after RST falls.
- Interface: one clock, CLK. Reset RST is asynchronous and active-high.
- RST high:
  - Immediately, without a clock: SYNC_RST = all 0, RST_DONE = 0, SW_RST_ACK = 0.
  - Synchroniser chain cleared, FSM = WAIT_SYNC, counter = 0.
- Synchroniser: NUM_STAGES flops, each asynchronously cleared by RST, with shift-in 1. Output rdy goes high at edge NUM_STAGES.
- FSM states: WAIT_SYNC, HOLD, RELEASE, DONE.
  - WAIT_SYNC: when rdy = 1, go to HOLD and clear the counter. The HOLD entry edge is NUM_STAGES.
  - HOLD: counter increments each edge. After MIN_ASSERT edges in HOLD:
    - set SYNC_RST[0] = 1;
    - if NUM_CH = 1, set RST_DONE = 1 and go to DONE;
    - otherwise go to RELEASE with channel index = 1 and counter = 0.
  - RELEASE: after GAP_CYCLES edges, set SYNC_RST[idx] = 1 and increment idx. On releasing channel NUM_CH-1, set RST_DONE = 1 on the same edge and go to DONE.
  - DONE: hold all outputs.
- Hard-reset release timing (defaults): SYNC_RST[i] rises at edge NUM_STAGES + MIN_ASSERT + i*GAP_CYCLES, i.e. edges 6, 14, 22, 30. RST_DONE rises at edge 30.
- Released channels stay high until the next assertion.
- Software reset:
  - SW_RST_REQ is sampled high at edge e in state HOLD, RELEASE or DONE. It is ignored in WAIT_SYNC.
  - At edge e: SYNC_RST = all 0, RST_DONE = 0, SW_RST_ACK = 1 for exactly one cycle, FSM = HOLD, counter = 0, idx = 0.
  - Sequence then repeats: SYNC_RST[0] rises at e + MIN_ASSERT, SYNC_RST[i] at e + MIN_ASSERT + i*GAP_CYCLES.
  - Request mid-sequence restarts from the beginning. Already-released channels are re-asserted synchronously.
  - Request held high: re-accepted every edge. ACK stays high and outputs stay asserted until the request drops.
- RST asserted mid-sequence overrides everything asynchronously.
- RST and SW_RST_REQ together: RST wins, and no ACK is issued.
- Counter width: clog2(max(MIN_ASSERT, GAP_CYCLES)) + 1. The counter must not wrap before its terminal count is reached.
- All outputs are driven directly from flops; no combinational path from an input to an output.

Decomposition:
- Shared package/include rst_seq_defs:
  - FSM state encodings;
  - clog2 function;
  - parameter legality checks (elaboration error if NUM_STAGES < 2, NUM_CH < 1, MIN_ASSERT < 1 or GAP_CYCLES < 1).
- One sub-module, rst_sync_chain: NUM_STAGES-deep, async-assert / sync-deassert synchroniser producing rdy. The top level holds the FSM, counter and output register bank.

Test Plan:
- Power-on, defaults: RST=1 for 3 cycles, then 0 before edge 1 -> SYNC_RST = 0000 through edge 5; 0001 at edge 6; 0011 at 14; 0111 at 22; 1111 at 30, with RST_DONE=1 at edge 30.
- Async assert: RST pulses high between edges 40 and 41 while in DONE -> SYNC_RST = 0000 and RST_DONE = 0 within the same cycle, with no clock edge required; release sequence restarts at edge NUM_STAGES after the new deassertion.
- Software reset in DONE: SW_RST_REQ=1 for one cycle sampled at edge 50 -> SW_RST_ACK=1 only in cycle 50-51; SYNC_RST = 0000 at 50; 0001 at 54; 1111 at 78.
- Mid-sequence restart: SW_RST_REQ sampled at edge 16 (SYNC_RST = 0011) -> 0000 at 16; 0001 at 20; RST_DONE at 44.
- Collision and WAIT_SYNC: RST and SW_RST_REQ both high -> no ACK. SW_RST_REQ during WAIT_SYNC at edge 1 -> no ACK and normal release timing.
- Corner parameters: NUM_CH=1, NUM_STAGES=3, MIN_ASSERT=1, GAP_CYCLES=1 -> SYNC_RST[0] and RST_DONE rise together at edge 4.
